// File: rtl/sram_access_ctrl_if.sv
// Request/response and bit-cell timing bundle between a requester,
// the SRAM access sequencer and the word-line decoder / bit-line array.
interface sram_access_ctrl_if #(
  parameter int ADR_W  = 4,
  parameter int DATA_W = 8
) ();
  logic              REQ_VALID;
  logic              REQ_READY;
  logic              REQ_WE;
  logic [ADR_W-1:0]  REQ_ADR;
  logic [DATA_W-1:0] REQ_WDATA;
  logic [ADR_W-1:0]  ADR;
  logic              WL_EN;
  logic              PRE;
  logic              WE;
  logic [DATA_W-1:0] BL_WDATA;
  logic              SAE;
  logic [DATA_W-1:0] BL_RDATA;
  logic              RSP_VALID;
  logic [DATA_W-1:0] RSP_RDATA;

  modport slave (
    input  REQ_VALID, REQ_WE, REQ_ADR, REQ_WDATA, BL_RDATA,
    output REQ_READY, ADR, WL_EN, PRE, WE, BL_WDATA, SAE,
    output RSP_VALID, RSP_RDATA
  );

  modport master (
    output REQ_VALID, REQ_WE, REQ_ADR, REQ_WDATA, BL_RDATA,
    input  REQ_READY, ADR, WL_EN, PRE, WE, BL_WDATA, SAE,
    input  RSP_VALID, RSP_RDATA
  );
endinterface

// File: rtl/sram_access_ctrl.sv
// SRAM access sequencer: one request at a time, Moore-decoded
// precharge / word-line / write / sense timing toward the bit cells.
module sram_access_ctrl #(
  parameter int ADR_W     = 4,
  parameter int DATA_W    = 8,
  parameter int PRE_CYC   = 1,
  parameter int SENSE_CYC = 1
) (
  input logic               CLK,
  input logic               RST_N,
  sram_access_ctrl_if.slave bus
);

  localparam int MAXC  = (PRE_CYC > SENSE_CYC) ? PRE_CYC : SENSE_CYC;
  localparam int CNT_W = (MAXC > 1) ? $clog2(MAXC) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRECH,
    S_ACCESS,
    S_SENSE,
    S_DONE
  } state_t;

  state_t             r_state;
  state_t             w_next;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_op_we;
  logic [ADR_W-1:0]   r_adr;
  logic [DATA_W-1:0]  r_wdata;
  logic [DATA_W-1:0]  r_rdata;

  logic w_idle;
  logic w_pre;
  logic w_wl;
  logic w_we;
  logic w_sae;
  logic w_done;
  logic w_accept;
  logic w_cnt_zero;

  assign w_cnt_zero = (r_cnt == '0);
  assign w_accept   = w_idle && bus.REQ_VALID;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    w_idle = 1'b0;
    w_pre  = 1'b0;
    w_wl   = 1'b0;
    w_we   = 1'b0;
    w_sae  = 1'b0;
    w_done = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        w_idle = 1'b1;
        if (bus.REQ_VALID) w_next = S_PRECH;
      end
      S_PRECH: begin
        w_pre = 1'b1;
        if (w_cnt_zero) w_next = S_ACCESS;
      end
      S_ACCESS: begin
        w_wl   = 1'b1;
        w_we   = r_op_we;
        w_next = r_op_we ? S_DONE : S_SENSE;
      end
      S_SENSE: begin
        w_wl  = 1'b1;
        w_sae = 1'b1;
        if (w_cnt_zero) w_next = S_DONE;
      end
      S_DONE: begin
        w_done = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Counter only decrements while non-zero, so it never wraps.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_cnt <= '0;
    end else if (w_accept) begin
      r_cnt <= CNT_W'(PRE_CYC - 1);
    end else if (r_state == S_ACCESS) begin
      r_cnt <= CNT_W'(SENSE_CYC - 1);
    end else if ((w_pre || w_sae) && !w_cnt_zero) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_op_we <= 1'b0;
      r_adr   <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
    end else begin
      if (w_accept) begin
        r_op_we <= bus.REQ_WE;
        r_adr   <= bus.REQ_ADR;
        r_wdata <= bus.REQ_WDATA;
      end
      if (w_sae && w_cnt_zero) r_rdata <= bus.BL_RDATA;
    end
  end

  assign bus.REQ_READY = w_idle && RST_N;
  assign bus.ADR       = r_adr;
  assign bus.BL_WDATA  = r_wdata;
  assign bus.PRE       = w_pre;
  assign bus.WL_EN     = w_wl;
  assign bus.WE        = w_we;
  assign bus.SAE       = w_sae;
  assign bus.RSP_VALID = w_done;
  assign bus.RSP_RDATA = r_rdata;

endmodule

// File: tb/tb_sram_access_ctrl.sv
// Scoreboard bench: random and directed requests against a queue of
// expected responses, plus a second instance with stretched timing.
module tb_sram_access_ctrl;

  localparam int P_PRE = 1;
  localparam int P_SEN = 1;

  typedef struct {
    logic       we;
    logic [3:0] adr;
    logic [7:0] wd;
    logic [7:0] rd;
    int         cyc;
  } exp_t;

  logic CLK   = 1'b0;
  logic RST_N = 1'b0;
  int   cyc   = 0;
  int   total = 0;
  int   bad   = 0;

  exp_t       q[$];
  logic [7:0] ref_mem[16];
  logic [7:0] arr[16];
  logic [7:0] last_rd = 8'h00;

  sram_access_ctrl_if #(.ADR_W(4), .DATA_W(8)) bus ();
  sram_access_ctrl_if #(.ADR_W(4), .DATA_W(8)) b2 ();

  sram_access_ctrl #(
    .ADR_W(4), .DATA_W(8), .PRE_CYC(P_PRE), .SENSE_CYC(P_SEN)
  ) u_dut (
    .CLK(CLK), .RST_N(RST_N), .bus(bus)
  );

  sram_access_ctrl #(
    .ADR_W(4), .DATA_W(8), .PRE_CYC(3), .SENSE_CYC(2)
  ) u_dut2 (
    .CLK(CLK), .RST_N(RST_N), .bus(b2)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  function automatic logic [7:0] init_val(input int i);
    return (i == 15) ? 8'h3C : 8'(i * 37 + 11);
  endfunction

  function automatic int lat(input logic we);
    return we ? P_PRE + 2 : P_PRE + P_SEN + 2;
  endfunction

  // Behavioural bit-cell array seen by the main instance.
  always @(posedge CLK) begin
    if (cyc == 0) begin
      for (int i = 0; i < 16; i++) arr[i] <= init_val(i);
    end else if (bus.WE) begin
      arr[bus.ADR] <= bus.BL_WDATA;
    end
  end
  assign bus.BL_RDATA = bus.SAE ? arr[bus.ADR] : 8'hEE;
  assign b2.BL_RDATA  = b2.SAE ? 8'h5A : 8'hFF;

  task automatic chk(input string nm, input logic [31:0] a,
                     input logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", nm, a, e, $time);
    end
  endtask

  // Monitor: pops the scoreboard whenever the DUT responds.
  always @(negedge CLK) begin
    if (RST_N) begin
      chk("inv", {30'd0, bus.PRE & bus.WL_EN, bus.WE & bus.SAE}, 32'd0);
      if (bus.WE) begin
        if (q.size() == 0) chk("we_unexp", 32'd1, 32'd0);
        else chk("wr_bus",
                 {19'd0, 1'b1, bus.ADR, bus.BL_WDATA},
                 {19'd0, q[0].we, q[0].adr, q[0].wd});
      end
      if (bus.RSP_VALID) begin
        if (q.size() == 0) begin
          chk("rsp_unexp", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("rsp_lat", cyc, e.cyc);
          if (!e.we) begin
            chk("rdata", {24'd0, bus.RSP_RDATA}, {24'd0, e.rd});
            last_rd = e.rd;
          end else begin
            chk("rdata_hold", {24'd0, bus.RSP_RDATA}, {24'd0, last_rd});
          end
        end
      end
    end
  end

  task automatic issue(input logic we, input logic [3:0] adr,
                       input logic [7:0] wd, output int acc);
    exp_t e;
    bit   ok;
    ok  = 1'b0;
    acc = -1;
    bus.REQ_VALID = 1'b1;
    bus.REQ_WE    = we;
    bus.REQ_ADR   = adr;
    bus.REQ_WDATA = wd;
    for (int t = 0; t < 50 && !ok; t++) begin
      if (bus.REQ_READY) begin
        ok    = 1'b1;
        acc   = cyc;
        e.we  = we;
        e.adr = adr;
        e.wd  = wd;
        e.rd  = we ? 8'h00 : ref_mem[adr];
        e.cyc = cyc + lat(we);
        q.push_back(e);
        if (we) ref_mem[adr] = wd;
      end
      @(negedge CLK);
    end
    bus.REQ_VALID = 1'b0;
    if (!ok) chk("accept_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    int a0;
    int a1;
    int k;
    int npre;
    int nsae;
    int nrdy;
    int rc;
    logic [7:0] rd2;
    for (int i = 0; i < 16; i++) ref_mem[i] = init_val(i);
    bus.REQ_VALID = 1'b0;
    bus.REQ_WE    = 1'b0;
    bus.REQ_ADR   = '0;
    bus.REQ_WDATA = '0;
    b2.REQ_VALID  = 1'b0;
    b2.REQ_WE     = 1'b0;
    b2.REQ_ADR    = '0;
    b2.REQ_WDATA  = '0;

    repeat (3) @(negedge CLK);
    chk("reset_outs",
        {9'd0, bus.REQ_READY, bus.PRE, bus.WL_EN, bus.WE, bus.SAE,
         bus.RSP_VALID, bus.ADR, bus.BL_WDATA, bus.RSP_RDATA},
        32'd0);
    RST_N = 1'b1;
    @(negedge CLK);
    chk("idle_ready", {27'd0, bus.REQ_READY, bus.PRE, bus.WL_EN,
                       bus.SAE, bus.WE}, 32'b10000);

    // Directed write then its cycle-by-cycle bit-cell controls.
    issue(1'b1, 4'h5, 8'hA3, a0);
    chk("w_pre", {31'd0, bus.PRE}, 32'd1);
    @(negedge CLK);
    chk("w_access", {18'd0, bus.WL_EN, bus.WE, bus.ADR, bus.BL_WDATA},
        {18'd0, 2'b11, 4'h5, 8'hA3});
    repeat (2) @(negedge CLK);
    chk("w_ready_c4", {31'd0, bus.REQ_READY}, 32'd1);

    issue(1'b0, 4'hF, 8'h00, a0);
    repeat (4) @(negedge CLK);

    // Back-to-back write then read to the same word.
    issue(1'b1, 4'h0, 8'h77, a0);
    issue(1'b0, 4'h0, 8'h00, a1);
    chk("b2b_gap", a1 - a0, 32'd4);
    repeat (5) @(negedge CLK);

    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 2) == 0)
        repeat ($urandom_range(1, 3)) @(negedge CLK);
      issue(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
            8'($urandom_range(0, 255)), a0);
    end
    repeat (6) @(negedge CLK);

    // Reset during a read's sense phase.
    issue(1'b0, 4'h9, 8'h00, a0);
    rc = 0;
    for (int t = 0; t < 10 && rc == 0; t++) begin
      if (bus.SAE) rc = 1;
      else @(negedge CLK);
    end
    chk("sae_seen", rc, 32'd1);
    #2 RST_N = 1'b0;
    #1;
    chk("rst_async", {25'd0, bus.SAE, bus.WL_EN, bus.PRE, bus.WE,
                      bus.RSP_VALID, bus.REQ_READY, |bus.RSP_RDATA},
        32'd0);
    q.delete();
    last_rd = 8'h00;
    repeat (2) @(negedge CLK);
    RST_N = 1'b1;
    @(negedge CLK);
    issue(1'b1, 4'h2, 8'h4D, a0);
    repeat (4) @(negedge CLK);

    // Stretched timing: PRE 3 cycles, SAE 2 cycles, response in cycle 7.
    b2.REQ_VALID = 1'b1;
    b2.REQ_WE    = 1'b0;
    b2.REQ_ADR   = 4'h7;
    k = -1;
    for (int t = 0; t < 10 && k < 0; t++) begin
      if (b2.REQ_READY) k = cyc;
      else @(negedge CLK);
    end
    chk("b2_accept", {31'd0, k >= 0}, 32'd1);
    npre = 0;
    nsae = 0;
    nrdy = 0;
    rc   = -1;
    rd2  = 8'h00;
    for (int t = 0; t < 20 && rc < 0; t++) begin
      @(negedge CLK);
      npre += int'(b2.PRE);
      nsae += int'(b2.SAE);
      nrdy += int'(b2.REQ_READY);
      if (b2.RSP_VALID) begin
        rc  = cyc;
        rd2 = b2.RSP_RDATA;
      end
    end
    b2.REQ_VALID = 1'b0;
    chk("b2_lat", rc - k, 32'd7);
    chk("b2_pre_cnt", npre, 32'd3);
    chk("b2_sae_cnt", nsae, 32'd2);
    chk("b2_busy_ready", nrdy, 32'd0);
    chk("b2_rdata", {24'd0, rd2}, 32'h5A);
    @(negedge CLK);
    chk("b2_ready_back", {31'd0, b2.REQ_READY}, 32'd1);

    for (int t = 0; t < 20 && q.size() != 0; t++) @(negedge CLK);
    chk("drain", q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
